kbd_decode: RTL and testbench

- Downstream consumer of the ps2_keyboard byte FIFO.
- Pops raw set-2 scan-code bytes from that FIFO and tracks make/break (F0) and extended (E0) prefixes.
- Maintains the current key, its ASCII value and a BCD press counter.
- Drives six active-low seven-segment digits for the board display.
- Sits between ps2_keyboard and the seg0..seg5 board outputs.

---
 rtl/kbd_decode_if.sv | 22 ++
 rtl/kbd_decode.sv | 176 +++++++++++++++++
 tb/tb_kbd_decode.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_decode_if.sv
// Byte-FIFO handshake between ps2_keyboard (master) and kbd_decode (slave).
// The FIFO advances on a clk edge where kbd_ready=1 and kbd_nextdata_n=0.
interface kbd_decode_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;

  modport master (
    output kbd_data,
    output kbd_ready,
    output kbd_overflow,
    input  kbd_nextdata_n
  );

  modport slave (
    input  kbd_data,
    input  kbd_ready,
    input  kbd_overflow,
    output kbd_nextdata_n
  );
endinterface

// File: rtl/kbd_decode.sv
// Set-2 scan-code decoder: pops bytes from the ps2_keyboard FIFO, tracks E0/F0
// prefixes, keeps the current key, its ASCII and a BCD press counter, drives 7-seg.
module kbd_decode #(
  parameter bit BLANK_ON_RELEASE = 1'b1,
  parameter int CNT_DIGITS       = 2
) (
  input  logic         clk,
  input  logic         resetn,
  kbd_decode_if.slave  kbd,
  output logic         key_down,
  output logic [7:0]   cur_code,
  output logic         cur_ext,
  output logic [7:0]   cur_ascii,
  output logic [7:0]   press_cnt,
  output logic         ovf_sticky,
  output logic [7:0]   seg0,
  output logic [7:0]   seg1,
  output logic [7:0]   seg2,
  output logic [7:0]   seg3,
  output logic [7:0]   seg4,
  output logic [7:0]   seg5
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] byte_reg;
  logic       brk_reg, ext_reg;
  logic       key_down_reg, cur_ext_reg, ovf_reg, nextdata_n_reg;
  logic [7:0] cur_code_reg, cur_ascii_reg;
  logic       do_decode, is_e0, is_f0, same_key, new_make;
  logic [CNT_DIGITS-1:0] carry;

  function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
        8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
        8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
        8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
        8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
        8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
        8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        8'h29: a = 8'h20;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (kbd.kbd_ready) state_next = POP;
      POP:     state_next = DECODE;
      DECODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_decode = (state_reg == DECODE);
  assign is_e0     = (byte_reg == 8'hE0);
  assign is_f0     = (byte_reg == 8'hF0);
  assign same_key  = (byte_reg == cur_code_reg) && (ext_reg == cur_ext_reg);
  assign new_make  = do_decode && !is_e0 && !is_f0 && !brk_reg && !(key_down_reg && same_key);

  // The pop strobe is a flop loaded from state_next so it cannot glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      nextdata_n_reg <= 1'b1;
      byte_reg       <= 8'h00;
      brk_reg        <= 1'b0;
      ext_reg        <= 1'b0;
      key_down_reg   <= 1'b0;
      cur_code_reg   <= 8'h00;
      cur_ext_reg    <= 1'b0;
      cur_ascii_reg  <= 8'h00;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      nextdata_n_reg <= (state_next != POP);
      if (kbd.kbd_overflow) ovf_reg <= 1'b1;
      if (state_reg == IDLE && kbd.kbd_ready) byte_reg <= kbd.kbd_data;
      if (do_decode) begin
        if (is_e0) begin
          ext_reg <= 1'b1;
        end else if (is_f0) begin
          brk_reg <= 1'b1;
        end else begin
          brk_reg <= 1'b0;
          ext_reg <= 1'b0;
          if (brk_reg) begin
            if (same_key) key_down_reg <= 1'b0;
          end else if (new_make) begin
            cur_code_reg  <= byte_reg;
            cur_ext_reg   <= ext_reg;
            cur_ascii_reg <= ascii_lut(byte_reg, ext_reg);
            key_down_reg  <= 1'b1;
          end
        end
      end
    end
  end

  // BCD press counter, one ripple-carry digit per generate slice.
  assign carry[0] = new_make;
  genvar gi;
  generate
    for (gi = 0; gi < CNT_DIGITS; gi++) begin : g_bcd
      logic [3:0] digit_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
          digit_reg <= 4'd0;
        else if (carry[gi])
          digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end
      if (gi < CNT_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit_reg == 4'd9);
      end
      assign press_cnt[4*gi +: 4] = digit_reg;
    end
  endgenerate

  logic [3:0] seg_nib [6];
  logic [7:0] seg_val [6];
  assign seg_nib[0] = cur_code_reg[3:0];
  assign seg_nib[1] = cur_code_reg[7:4];
  assign seg_nib[2] = cur_ascii_reg[3:0];
  assign seg_nib[3] = cur_ascii_reg[7:4];
  assign seg_nib[4] = press_cnt[3:0];
  assign seg_nib[5] = press_cnt[7:4];

  generate
    for (gi = 0; gi < 6; gi++) begin : g_seg
      localparam bit BLANKABLE = (gi < 4);
      assign seg_val[gi] = (BLANK_ON_RELEASE && BLANKABLE && !key_down_reg) ? 8'hFF
                                                                           : hex7(seg_nib[gi]);
    end
  endgenerate

  assign seg0 = seg_val[0];
  assign seg1 = seg_val[1];
  assign seg2 = seg_val[2];
  assign seg3 = seg_val[3];
  assign seg4 = seg_val[4];
  assign seg5 = seg_val[5];

  assign kbd.kbd_nextdata_n = nextdata_n_reg;
  assign key_down   = key_down_reg;
  assign cur_code   = cur_code_reg;
  assign cur_ext    = cur_ext_reg;
  assign cur_ascii  = cur_ascii_reg;
  assign ovf_sticky = ovf_reg;

endmodule

// File: tb/tb_kbd_decode.sv
// Scoreboard bench for kbd_decode: a FIFO model feeds bytes, a prefix-list reference
// model predicts the state after each byte, and a monitor checks it after every pop.
module tb_kbd_decode;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_down, cur_ext, ovf_sticky;
  logic [7:0] cur_code, cur_ascii, press_cnt;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

  kbd_decode_if kbd();

  kbd_decode #(.BLANK_ON_RELEASE(1'b1), .CNT_DIGITS(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .kbd        (kbd),
    .key_down   (key_down),
    .cur_code   (cur_code),
    .cur_ext    (cur_ext),
    .cur_ascii  (cur_ascii),
    .press_cnt  (press_cnt),
    .ovf_sticky (ovf_sticky),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .seg5       (seg5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  b;
    logic        down;
    logic [7:0]  code;
    logic        ext;
    logic [7:0]  ascii;
    logic [7:0]  cnt;
    logic [47:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] prefix_q[$];
  int total = 0, bad = 0, pushes = 0, pops = 0, txn = 0;

  bit         m_down = 1'b0, m_ext = 1'b0;
  logic [7:0] m_code = 8'h00, m_ascii = 8'h00;
  int         m_cnt = 0;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] pool [6] = '{8'h1C, 8'h16, 8'h29, 8'h75, 8'h1A, 8'h45};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit e);
    logic [7:0] a;
    a = 8'h00;
    if (!e) begin
      for (int i = 0; i < 26; i++) if (let_codes[i] == c) a = 8'(8'h41 + i);
      for (int i = 0; i < 10; i++) if (dig_codes[i] == c) a = 8'(8'h30 + i);
      if (c == 8'h29) a = 8'h20;
    end
    return a;
  endfunction

  function automatic logic [47:0] ref_seg(input bit down, input logic [7:0] code,
                                          input logic [7:0] ascii, input int cnt);
    logic [7:0] s [6];
    s[0] = down ? font[code % 16]  : 8'hFF;
    s[1] = down ? font[code / 16]  : 8'hFF;
    s[2] = down ? font[ascii % 16] : 8'hFF;
    s[3] = down ? font[ascii / 16] : 8'hFF;
    s[4] = font[cnt % 10];
    s[5] = font[cnt / 10];
    return {s[5], s[4], s[3], s[2], s[1], s[0]};
  endfunction

  // Prefixes accumulate in a list; a non-prefix byte consumes the whole list.
  task automatic model_push(input logic [7:0] b);
    exp_t e;
    bit ext, brk, same;
    if (b == 8'hE0 || b == 8'hF0) begin
      prefix_q.push_back(b);
    end else begin
      ext = 1'b0;
      brk = 1'b0;
      foreach (prefix_q[i]) begin
        if (prefix_q[i] == 8'hE0) ext = 1'b1;
        if (prefix_q[i] == 8'hF0) brk = 1'b1;
      end
      prefix_q.delete();
      same = (b == m_code) && (ext == m_ext);
      if (brk) begin
        if (same) m_down = 1'b0;
      end else if (!(m_down && same)) begin
        m_code  = b;
        m_ext   = ext;
        m_ascii = ref_ascii(b, ext);
        m_down  = 1'b1;
        m_cnt   = (m_cnt + 1) % 100;
      end
    end
    e.b     = b;
    e.down  = m_down;
    e.code  = m_code;
    e.ext   = m_ext;
    e.ascii = m_ascii;
    e.cnt   = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    e.seg   = ref_seg(m_down, m_code, m_ascii, m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushes++;
    model_push(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(fifo_q.size() + exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_reset();
    @(negedge clk);
    resetn = 1'b0;
    prefix_q.delete();
    m_down = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_ascii = 8'h00; m_cnt = 0;
    @(negedge clk);
  endtask

  // FIFO model: pop on an edge with ready=1 and nextdata_n=0, then present the new head.
  always @(posedge clk) begin
    if (resetn && kbd.kbd_ready && !kbd.kbd_nextdata_n && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    #1;
    kbd.kbd_ready = (fifo_q.size() != 0);
    kbd.kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && !kbd.kbd_nextdata_n) begin
      @(negedge clk);
      chk("strobe_width", 64'(kbd.kbd_nextdata_n), 64'd1);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d byte=%h down=%0d code=%h ext=%0d ascii=%h cnt=%h",
                 txn, e.b, key_down, cur_code, cur_ext, cur_ascii, press_cnt);
        chk("key_down",  64'(key_down),  64'(e.down));
        chk("cur_code",  64'(cur_code),  64'(e.code));
        chk("cur_ext",   64'(cur_ext),   64'(e.ext));
        chk("cur_ascii", 64'(cur_ascii), 64'(e.ascii));
        chk("press_cnt", 64'(press_cnt), 64'(e.cnt));
        chk("segs", 64'({seg5, seg4, seg3, seg2, seg1, seg0}), 64'(e.seg));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kbd.kbd_overflow = 1'b0;
    kbd.kbd_ready    = 1'b0;
    kbd.kbd_data     = 8'h00;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", 64'(kbd.kbd_nextdata_n), 64'd1);
    chk("rst_key_down", 64'(key_down), 64'd0);
    chk("rst_code", 64'({cur_code, cur_ascii, 7'd0, cur_ext}), 64'd0);
    chk("rst_press_cnt", 64'(press_cnt), 64'h00);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    chk("rst_seg03", 64'({seg3, seg2, seg1, seg0}), 64'hFFFF_FFFF);
    chk("rst_seg45", 64'({seg5, seg4}), 64'hC0C0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_nextdata_n", 64'(kbd.kbd_nextdata_n), 64'd1);
    chk("idle_state", 64'({key_down, press_cnt, seg3, seg2, seg1, seg0}), 64'h0_00_FFFF_FFFF);

    push(8'h1C);
    drain();
    chk("a_key", 64'({key_down, cur_code, cur_ascii, press_cnt}), 64'h1_1C_41_01);
    chk("a_seg", 64'({seg3, seg2, seg1, seg0}), 64'h99F9_F9C6);

    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("typematic_cnt", 64'(press_cnt), 64'h01);
    chk("release_down", 64'(key_down), 64'd0);
    chk("release_seg", 64'({seg3, seg2, seg1, seg0}), 64'hFFFF_FFFF);

    push(8'hE0); push(8'h75);
    drain();
    chk("ext_make", 64'({cur_ext, cur_ascii, press_cnt}), 64'h1_00_02);
    push(8'hF0); push(8'h75);
    drain();
    chk("ext_mismatch_held", 64'(key_down), 64'd1);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("ext_release", 64'({key_down, press_cnt}), 64'h0_02);

    @(negedge clk) kbd.kbd_overflow = 1'b1;
    @(negedge clk) kbd.kbd_overflow = 1'b0;
    chk("ovf_set", 64'(ovf_sticky), 64'd1);

    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        case ($urandom_range(0, 9))
          0, 1:    push(8'hE0);
          2, 3:    push(8'hF0);
          4:       push(8'($urandom_range(0, 255)));
          default: push(pool[$urandom_range(0, 5)]);
        endcase
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain();
    chk("ovf_hold", 64'(ovf_sticky), 64'd1);

    push(8'hF0);
    drain();
    start_reset();
    chk("reset_ovf_clear", 64'(ovf_sticky), 64'd0);
    resetn = 1'b1;
    push(8'h1C);
    drain();
    chk("post_reset_make", 64'({key_down, cur_code, press_cnt}), 64'h1_1C_01);

    start_reset();
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push(8'h16); push(8'hF0); push(8'h16);
    end
    drain();
    chk("wrap_cnt", 64'(press_cnt), 64'h00);
    chk("wrap_ascii", 64'({key_down, cur_ascii}), 64'h0_31);
    chk("pop_count", 64'(pops), 64'(pushes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
